sq_slot_sched: RTL and testbench



---
 rtl/sq_slot_sched.sv | 189 ++++++++++++++++++
 tb/tb_sq_slot_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_slot_sched.sv
// Time-division slot scheduler: SLOTS operator slots share one sin/pow datapath,
// each owning a fixed window inside a FRAME-cycle sample frame.
module sq_slot_sched #(
    parameter int unsigned SLOTS     = 8,
    parameter int unsigned FRAME     = 144,
    parameter int unsigned WIN       = 16,
    parameter int unsigned WIN_START = 8,
    parameter int unsigned CAP_OFS   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_slot,
    input  logic [10:0] cfg_fnumber,
    input  logic [2:0]  cfg_block,
    input  logic [3:0]  cfg_multiple,
    input  logic [6:0]  cfg_totallvl,
    input  logic        cfg_keyon,
    output logic [9:0]  phase,
    output logic [6:0]  gain,
    output logic        pow_rd_n,
    input  logic [13:0] pow_y,
    output logic [16:0] mix,
    output logic        sample_valid,
    output logic [2:0]  busy_slot
);
    localparam int unsigned FCW = $clog2(FRAME);
    localparam int unsigned SW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAME - 1);
    localparam logic [FCW-1:0] OFS_RD   = FCW'(2);
    localparam logic [FCW-1:0] OFS_CAP  = FCW'(CAP_OFS);
    localparam logic [FCW-1:0] OFS_LAST = FCW'(WIN - 1);

    typedef struct packed {
        logic [10:0] fnumber;
        logic [2:0]  block;
        logic [3:0]  multiple;
        logic [6:0]  totallvl;
        logic        keyon;
    } cfg_t;

    logic [FCW-1:0] fc_q, fc_d;
    logic [9:0]     phase_q, phase_d;
    logic [6:0]     gain_q, gain_d;
    logic           pow_rd_n_q, pow_rd_n_d;
    logic [16:0]    mix_q, mix_d;
    logic [16:0]    mix_acc_q, mix_acc_d;
    logic           sv_q, sv_d;
    logic [2:0]     busy_q, busy_d;
    cfg_t           shadow_q [SLOTS];
    cfg_t           shadow_d [SLOTS];
    cfg_t           active_q [SLOTS];
    cfg_t           active_d [SLOTS];
    logic [19:0]    acc_q [SLOTS];
    logic [19:0]    acc_d [SLOTS];

    logic           in_win;
    logic [SW-1:0]  win_slot;
    logic [FCW-1:0] win_off;
    cfg_t           cur_cfg;
    cfg_t           cfg_in;
    logic [19:0]    fmult;
    logic [19:0]    cur_inc;

    assign cfg_in = '{fnumber:  cfg_fnumber,
                      block:    cfg_block,
                      multiple: cfg_multiple,
                      totallvl: cfg_totallvl,
                      keyon:    cfg_keyon};

    always_comb begin
        in_win   = 1'b0;
        win_slot = '0;
        win_off  = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (fc_q >= FCW'(WIN_START + k * WIN) && fc_q < FCW'(WIN_START + (k + 1) * WIN)) begin
                in_win   = 1'b1;
                win_slot = SW'(k);
                win_off  = fc_q - FCW'(WIN_START + k * WIN);
            end
        end
    end

    assign cur_cfg = active_q[win_slot];

    // One shared increment unit serves whichever slot owns the current window.
    always_comb begin
        if (cur_cfg.block == 3'd0) begin
            fmult = {9'b0, cur_cfg.fnumber} >> 1;
        end else begin
            fmult = {9'b0, cur_cfg.fnumber} << (cur_cfg.block - 3'd1);
        end
        if (cur_cfg.multiple == 4'd0) begin
            cur_inc = fmult >> 1;
        end else begin
            cur_inc = fmult * {16'b0, cur_cfg.multiple};
        end
    end

    always_comb begin
        fc_d       = (fc_q == FC_LAST) ? '0 : fc_q + FCW'(1);
        phase_d    = phase_q;
        gain_d     = gain_q;
        pow_rd_n_d = 1'b1;
        mix_d      = mix_q;
        mix_acc_d  = mix_acc_q;
        sv_d       = 1'b0;
        busy_d     = busy_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        acc_d      = acc_q;

        if (in_win) begin
            busy_d = 3'(win_slot);
            if (win_off == '0) begin
                phase_d = acc_q[win_slot][19:10];
                gain_d  = cur_cfg.totallvl;
            end
            if (cur_cfg.keyon) begin
                if (win_off == OFS_RD) begin
                    pow_rd_n_d = 1'b0;
                end
                if (win_off == OFS_CAP) begin
                    mix_acc_d = mix_acc_q + {{3{pow_y[13]}}, pow_y};
                end
                if (win_off == OFS_LAST) begin
                    acc_d[win_slot] = acc_q[win_slot] + cur_inc;
                end
            end
        end

        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (cfg_we && cfg_slot == 3'(k)) begin
                shadow_d[k] = cfg_in;
            end
        end

        // Copy uses the post-write shadow so a same-cycle write takes effect next frame.
        if (fc_q == FC_LAST) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (shadow_d[k].keyon && !active_q[k].keyon) begin
                    acc_d[k] = '0;
                end
                active_d[k] = shadow_d[k];
            end
            mix_d     = mix_acc_d;
            mix_acc_d = '0;
            sv_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fc_q       <= '0;
            phase_q    <= '0;
            gain_q     <= '0;
            pow_rd_n_q <= 1'b1;
            mix_q      <= '0;
            mix_acc_q  <= '0;
            sv_q       <= 1'b0;
            busy_q     <= '0;
            for (int unsigned k = 0; k < SLOTS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
                acc_q[k]    <= '0;
            end
        end else begin
            fc_q       <= fc_d;
            phase_q    <= phase_d;
            gain_q     <= gain_d;
            pow_rd_n_q <= pow_rd_n_d;
            mix_q      <= mix_d;
            mix_acc_q  <= mix_acc_d;
            sv_q       <= sv_d;
            busy_q     <= busy_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            acc_q      <= acc_d;
        end
    end

    assign phase        = phase_q;
    assign gain         = gain_q;
    assign pow_rd_n     = pow_rd_n_q;
    assign mix          = mix_q;
    assign sample_valid = sv_q;
    assign busy_slot    = busy_q;

endmodule

// File: tb/tb_sq_slot_sched.sv
// Bench for sq_slot_sched: frame-level reference model checked every cycle,
// plus table-driven increment vectors and directed multi-cycle sequences.
module tb_sq_slot_sched;
    localparam int SLOTS     = 8;
    localparam int FRAME     = 144;
    localparam int WIN       = 16;
    localparam int WIN_START = 8;
    localparam int CAP_OFS   = 8;

    logic        clk;
    logic        reset_n;
    logic        cfg_we;
    logic [2:0]  cfg_slot;
    logic [10:0] cfg_fnumber;
    logic [2:0]  cfg_block;
    logic [3:0]  cfg_multiple;
    logic [6:0]  cfg_totallvl;
    logic        cfg_keyon;
    logic [9:0]  phase;
    logic [6:0]  gain;
    logic        pow_rd_n;
    logic [13:0] pow_y;
    logic [16:0] mix;
    logic        sample_valid;
    logic [2:0]  busy_slot;

    sq_slot_sched #(
        .SLOTS(SLOTS), .FRAME(FRAME), .WIN(WIN), .WIN_START(WIN_START), .CAP_OFS(CAP_OFS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
        .cfg_fnumber(cfg_fnumber), .cfg_block(cfg_block), .cfg_multiple(cfg_multiple),
        .cfg_totallvl(cfg_totallvl), .cfg_keyon(cfg_keyon), .phase(phase), .gain(gain),
        .pow_rd_n(pow_rd_n), .pow_y(pow_y), .mix(mix), .sample_valid(sample_valid),
        .busy_slot(busy_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    int pow_mode = 0;
    bit mon40 = 0;
    bit saw40 = 0;

    // Reference model state: "current fc", shadow/active config, accumulators.
    int m_fc = 0;
    int s_fn[SLOTS], s_blk[SLOTS], s_mul[SLOTS], s_tl[SLOTS], s_key[SLOTS];
    int a_fn[SLOTS], a_blk[SLOTS], a_mul[SLOTS], a_tl[SLOTS], a_key[SLOTS];
    int m_acc[SLOTS];
    int m_mix_acc = 0;
    int e_phase = 0, e_gain = 0, e_rd = 1, e_mix = 0, e_sv = 0, e_busy = 0;

    typedef struct {
        int fn;
        int blk;
        int mul;
        int frames;
        int exp_phase;
    } inc_vec_t;

    function automatic int inc_of(int fn, int blk, int mul);
        int fm;
        fm = (blk == 0) ? (fn >> 1) : (fn << (blk - 1));
        if (mul == 0) return fm >> 1;
        return (fm * mul) % (1 << 20);
    endfunction

    task automatic model_step();
        int k;
        int o;
        if (!reset_n) begin
            m_fc = 0; m_mix_acc = 0;
            e_phase = 0; e_gain = 0; e_rd = 1; e_mix = 0; e_sv = 0; e_busy = 0;
            for (int i = 0; i < SLOTS; i++) begin
                s_fn[i] = 0; s_blk[i] = 0; s_mul[i] = 0; s_tl[i] = 0; s_key[i] = 0;
                a_fn[i] = 0; a_blk[i] = 0; a_mul[i] = 0; a_tl[i] = 0; a_key[i] = 0;
                m_acc[i] = 0;
            end
            return;
        end
        e_sv = 0;
        e_rd = 1;
        if (m_fc >= WIN_START && m_fc < WIN_START + SLOTS * WIN) begin
            k = (m_fc - WIN_START) / WIN;
            o = (m_fc - WIN_START) % WIN;
            e_busy = k;
            if (o == 0) begin
                e_phase = m_acc[k] >> 10;
                e_gain  = a_tl[k];
            end
            if (a_key[k] != 0) begin
                if (o == 2) e_rd = 0;
                if (o == CAP_OFS) m_mix_acc += int'($signed(pow_y));
                if (o == WIN - 1)
                    m_acc[k] = (m_acc[k] + inc_of(a_fn[k], a_blk[k], a_mul[k])) % (1 << 20);
            end
        end
        if (cfg_we && int'(cfg_slot) < SLOTS) begin
            s_fn[cfg_slot] = cfg_fnumber; s_blk[cfg_slot] = cfg_block;
            s_mul[cfg_slot] = cfg_multiple; s_tl[cfg_slot] = cfg_totallvl;
            s_key[cfg_slot] = cfg_keyon;
        end
        if (m_fc == FRAME - 1) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (s_key[i] != 0 && a_key[i] == 0) m_acc[i] = 0;
                a_fn[i] = s_fn[i]; a_blk[i] = s_blk[i]; a_mul[i] = s_mul[i];
                a_tl[i] = s_tl[i]; a_key[i] = s_key[i];
            end
            e_mix = m_mix_acc;
            m_mix_acc = 0;
            e_sv = 1;
        end
        m_fc = (m_fc + 1) % FRAME;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_tests++;
            if (phase !== 10'(e_phase) || gain !== 7'(e_gain) || pow_rd_n !== 1'(e_rd) ||
                mix !== 17'(e_mix) || sample_valid !== 1'(e_sv) || busy_slot !== 3'(e_busy)) begin
                n_fail++;
                $display("FAIL model fc=%0d: phase %0d/%0d gain %0d/%0d rd %0d/%0d mix %0d/%0d sv %0d/%0d busy %0d/%0d (got/exp)",
                         m_fc, phase, e_phase, gain, e_gain, pow_rd_n, e_rd,
                         $signed(mix), e_mix, sample_valid, e_sv, busy_slot, e_busy);
            end
        end
        if (mon40 && gain == 7'h40) saw40 = 1;
    end

    // pow unit stand-in: per-slot constants in table mode, random otherwise.
    initial forever begin
        @(negedge clk);
        if (pow_mode == 1 && m_fc >= WIN_START && m_fc < WIN_START + SLOTS * WIN) begin
            case ((m_fc - WIN_START) / WIN)
                0:       pow_y = 14'(100);
                3:       pow_y = 14'(-30);
                default: pow_y = '0;
            endcase
        end else begin
            pow_y = 14'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fc(input int f);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (m_fc != f && n <= FRAME);
        if (m_fc != f) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_fc: fc %0d not reached, at %0d", f, m_fc);
        end
    endtask

    task automatic cfg_write(input int slot, input int fn, input int blk, input int mul,
                             input int tl, input int key);
        cfg_we = 1'b1;
        cfg_slot = 3'(slot); cfg_fnumber = 11'(fn); cfg_block = 3'(blk);
        cfg_multiple = 4'(mul); cfg_totallvl = 7'(tl); cfg_keyon = 1'(key);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " phase"}, int'(phase), 0);
        check({tag, " gain"}, int'(gain), 0);
        check({tag, " pow_rd_n"}, int'(pow_rd_n), 1);
        check({tag, " mix"}, int'(mix), 0);
        check({tag, " sample_valid"}, int'(sample_valid), 0);
        check({tag, " busy_slot"}, int'(busy_slot), 0);
    endtask

    inc_vec_t vecs[5];

    initial begin
        int sv_n, first_sv, second_sv, rd_lows, mix_nz, sv_at;

        vecs[0] = '{fn: 'h200, blk: 4, mul: 1,  frames: 3, exp_phase: 12};
        vecs[1] = '{fn: 'h7FF, blk: 0, mul: 0,  frames: 8, exp_phase: 3};
        vecs[2] = '{fn: 'h7FF, blk: 7, mul: 15, frames: 1, exp_phase: 'h37F};
        vecs[3] = '{fn: 'h7FF, blk: 7, mul: 15, frames: 2, exp_phase: 'h2FE};
        vecs[4] = '{fn: 'h100, blk: 1, mul: 2,  frames: 4, exp_phase: 2};

        reset_n = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_fnumber = '0; cfg_block = '0;
        cfg_multiple = '0; cfg_totallvl = '0; cfg_keyon = 1'b0; pow_y = '0;
        repeat (3) tick();
        chk_en = 1;
        check_reset_values("reset");

        // Idle frames: no strobes, mix stays 0, pulses at cycles 143 and 287.
        reset_n = 1'b1;
        sv_n = 0; first_sv = -1; second_sv = -1; rd_lows = 0; mix_nz = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (sample_valid) begin
                if (sv_n == 0) first_sv = i;
                else if (sv_n == 1) second_sv = i;
                sv_n++;
            end
            if (!pow_rd_n) rd_lows++;
            if (mix != '0) mix_nz++;
        end
        check("idle sv count", sv_n, 2);
        check("idle sv first", first_sv, 143);
        check("idle sv second", second_sv, 287);
        check("idle pow_rd_n lows", rd_lows, 0);
        check("idle mix nonzero", mix_nz, 0);

        // Slot 0 phase progression and read strobe timing.
        cfg_write(0, 'h200, 4, 1, 0, 1);
        wait_fc(0);
        for (int j = 0; j < 4; j++) begin
            wait_fc(9);
            check("slot0 phase", int'(phase), 4 * j);
            wait_fc(11);
            check("slot0 rd low after fc10", int'(pow_rd_n), 0);
            wait_fc(12);
            check("slot0 rd high after fc11", int'(pow_rd_n), 1);
        end

        // Two-slot mix and mid-frame key-off.
        pow_mode = 1;
        wait_fc(20);
        cfg_write(3, 'h123, 2, 3, 5, 1);
        wait_fc(0);
        wait_fc(0);
        check("mix two slots", int'($signed(mix)), 70);
        check("mix two slots sv", int'(sample_valid), 1);
        wait_fc(30);
        cfg_write(3, 'h123, 2, 3, 5, 0);
        wait_fc(0);
        check("mix keyoff same frame", int'($signed(mix)), 70);
        wait_fc(0);
        check("mix keyoff next frame", int'($signed(mix)), 100);
        pow_mode = 0;

        // Increment rule vectors on slot 0.
        for (int v = 0; v < 5; v++) begin
            cfg_write(0, vecs[v].fn, vecs[v].blk, vecs[v].mul, 0, 0);
            wait_fc(0);
            cfg_write(0, vecs[v].fn, vecs[v].blk, vecs[v].mul, 0, 1);
            wait_fc(0);
            repeat (vecs[v].frames + 1) wait_fc(9);
            check($sformatf("inc vec %0d phase", v), int'(phase), vecs[v].exp_phase);
        end

        // Shadow write-then-copy: 0x40 overwritten on the copy cycle.
        wait_fc(50);
        cfg_write(2, 0, 0, 0, 'h40, 0);
        mon40 = 1;
        wait_fc(143);
        cfg_write(2, 0, 0, 0, 'h10, 0);
        wait_fc(41);
        check("slot2 gain", int'(gain), 'h10);
        wait_fc(41);
        check("slot2 gain next frame", int'(gain), 'h10);
        mon40 = 0;
        check("slot2 gain 0x40 seen", int'(saw40), 0);

        // Mid-frame reset.
        wait_fc(60);
        reset_n = 1'b0;
        tick();
        check_reset_values("midreset");
        reset_n = 1'b1;
        sv_at = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (sample_valid) begin
                sv_at = i;
                break;
            end
        end
        check("midreset first sv", sv_at, 143);

        // Random configuration traffic against the reference model.
        for (int c = 0; c < 20 * FRAME; c++) begin
            cfg_we = ($urandom_range(0, 4) == 0);
            cfg_slot = 3'($urandom);
            cfg_fnumber = 11'($urandom);
            cfg_block = 3'($urandom);
            cfg_multiple = 4'($urandom);
            cfg_totallvl = 7'($urandom);
            cfg_keyon = ($urandom_range(0, 3) != 0);
            tick();
        end
        cfg_we = 1'b0;
        repeat (2 * FRAME) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
